// File: rtl/nanov_shift_pkg.sv
// nanov_shift_pkg: shared encodings for the digit-serial shift/rotate unit.
//   OP_* : {instr[30], funct3} encodings seen on the op port.
//   sh_mode_t : internal operation mode latched on start.
//   sh_decode : (op, rotate) -> sh_mode_t. Only op[3], op[2] and rotate matter.
package nanov_shift_pkg;

  localparam logic [3:0] OP_SLL = 4'b0001;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b1101;

  typedef enum logic [2:0] {
    SH_SLL = 3'd0,
    SH_SRL = 3'd1,
    SH_SRA = 3'd2,
    SH_ROL = 3'd3,
    SH_ROR = 3'd4
  } sh_mode_t;

  // op[2] is direction (1 = right). With rotate set, instr[30] is ignored.
  function automatic sh_mode_t sh_decode(input logic [3:0] op, input logic rotate);
    sh_mode_t m;
    if (rotate)     m = op[2] ? SH_ROR : SH_ROL;
    else if (!op[2]) m = SH_SLL;
    else            m = op[3] ? SH_SRA : SH_SRL;
    return m;
  endfunction

endpackage

// File: rtl/nanov_shift_bitsel.sv
// nanov_shift_bitsel: one result bit of a shift/rotate.
//   mode : operation mode
//   amt  : shift amount (log2 XLEN bits)
//   idx  : result bit index
//   a    : operand
//   r    : result bit idx
// Index arithmetic wraps naturally in log2(XLEN) bits, which gives the
// mod-XLEN behaviour rotates need; the extra carry bit of idx+amt tells
// right shifts when they have run off the top and must use the fill.
module nanov_shift_bitsel
  import nanov_shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BW   = $clog2(XLEN)
) (
  input  sh_mode_t          mode,
  input  logic [BW-1:0]     amt,
  input  logic [BW-1:0]     idx,
  input  logic [XLEN-1:0]   a,
  output logic              r
);

  logic [BW-1:0] lidx;
  logic [BW:0]   rsum;

  always_comb begin
    lidx = idx - amt;
    rsum = {1'b0, idx} + {1'b0, amt};
    r    = 1'b0;
    unique case (mode)
      SH_SLL:  r = (idx >= amt) ? a[lidx] : 1'b0;
      SH_ROL:  r = a[lidx];
      SH_SRL:  r = rsum[BW] ? 1'b0 : a[rsum[BW-1:0]];
      SH_SRA:  r = rsum[BW] ? a[XLEN-1] : a[rsum[BW-1:0]];
      SH_ROR:  r = a[rsum[BW-1:0]];
      default: r = 1'b0;
    endcase
  end

endmodule

// File: rtl/nanov_shift_serial.sv
// nanov_shift_serial: digit-serial shift/rotate, result emitted LSB digit first.
//   clk, rstn : clock, async active-low reset
//   start     : request op; taken when idle, or on the last unheld digit
//   op, rotate: {instr[30], funct3} and rotate select
//   a, b      : operand and amount, latched on accepted start
//   hold      : freeze the current digit while busy
//   d_out     : result[k*DIGIT +: DIGIT]; d_valid/busy while running
//   last      : current digit is the final one
// Outputs depend only on registered state.
module nanov_shift_serial
  import nanov_shift_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DIGIT = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [3:0]                op,
  input  logic                      rotate,
  input  logic [XLEN-1:0]           a,
  input  logic [$clog2(XLEN)-1:0]   b,
  input  logic                      hold,
  output logic [DIGIT-1:0]          d_out,
  output logic                      d_valid,
  output logic                      last,
  output logic                      busy
);

  localparam int N  = XLEN / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(XLEN);
  localparam int DL = $clog2(DIGIT);

  logic [KW-1:0]             k;
  logic [XLEN-1:0]           areg;
  logic [BW-1:0]             breg;
  sh_mode_t                  mreg;
  logic                      accept;
  logic [BW-1:0]             base;
  logic [DIGIT-1:0][BW-1:0]  idx;
  logic [DIGIT-1:0]          dig;

  assign last    = busy & (k == KW'(N - 1));
  assign accept  = start & (~busy | (last & ~hold));
  assign d_valid = busy;
  assign d_out   = busy ? dig : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy <= 1'b0;
      k    <= '0;
      areg <= '0;
      breg <= '0;
      mreg <= SH_SLL;
    end else if (accept) begin
      busy <= 1'b1;
      k    <= '0;
      areg <= a;
      breg <= b;
      mreg <= sh_decode(op, rotate);
    end else if (busy && !hold) begin
      if (last) begin
        busy <= 1'b0;
        k    <= '0;
      end else begin
        k    <= k + 1'b1;
      end
    end
  end

  // First bit index of the current digit: k * DIGIT, DIGIT a power of two.
  generate
    if (N == 1) begin : g_base_one
      assign base = '0;
    end else if (DIGIT == 1) begin : g_base_bit
      assign base = k;
    end else begin : g_base_dig
      assign base = {k, {DL{1'b0}}};
    end
  endgenerate

  for (genvar j = 0; j < DIGIT; j++) begin : g_idx
    assign idx[j] = base | BW'(j);
  end

  nanov_shift_bitsel #(.XLEN(XLEN), .BW(BW)) u_bit [DIGIT-1:0] (
    .mode (mreg),
    .amt  (breg),
    .idx  (idx),
    .a    (areg),
    .r    (dig)
  );

endmodule

// File: doc/nanov_shift_serial.md
# nanov_shift_serial

Digit-serial shift/rotate unit for the nanoV datapath, generalising the bit-serial shifter to a configurable word width and DIGIT bits per cycle. It adds rotate (Zbb ROL/ROR), its own operand register and step counter, and a start/hold/last handshake, so the core can issue a shift and consume the result LSB-digit first. It sits beside the ALU and feeds the destination-register shift path.

## Interface
Parameters:
- XLEN, 32, operand/result width; power of two, ≥ 8.
- DIGIT, 1, result bits emitted per cycle; power of two, divides XLEN (1..XLEN).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  request a new operation; accepted per Timing rules.
- op  in  4  {instr[30], funct3}: 0001 SLL, 0101 SRL, 1101 SRA; with rotate=1, 0001 ROL, 0101 ROR.
- rotate  in  1  selects rotate instead of shift.
- a  in  XLEN  operand, sampled on accepted start.
- b  in  $clog2(XLEN)  shift amount, sampled on accepted start.
- hold  in  1  freeze current digit while busy.
- d_out  out  DIGIT  current result digit (bits [k·DIGIT +: DIGIT]).
- d_valid  out  1  d_out is a valid digit (= busy).
- last  out  1  current digit is the final one (k = N−1, N = XLEN/DIGIT).
- busy  out  1  operation in progress.

## Operation
- Decode (only op[3], op[2], rotate used; op[1:0] ignored): dir = op[2] (0 left, 1 right); rotate=1 → rotate, instr[30] ignored; rotate=0, dir=1: op[3]=1 arithmetic (fill a[XLEN−1]), else logical (fill 0); left shifts fill 0.
- Accepted start latches a → areg, b → breg, mode → mreg; counter k ← 0; busy ← 1.
- Result bit i (0 ≤ i < XLEN), arithmetic in XLEN-bit index space:
  - SLL: i ≥ b ? areg[i−b] : 0. ROL: areg[(i−b) mod XLEN].
  - SRL/SRA: i+b < XLEN ? areg[i+b] : fill. ROR: areg[(i+b) mod XLEN].
- d_out = result[k·DIGIT +: DIGIT], combinational from registered state only (no path from a/b/op to outputs).
- States: IDLE (busy=0) and RUN (busy=1). RUN, hold=0: k increments; at k=N−1 → IDLE unless a start is accepted. RUN, hold=1: k, areg, breg, mreg, outputs frozen.
- b=0 yields result = a for all modes. DIGIT=XLEN: N=1, counter width forced to 1 and unused, last = busy.
- Reset (any time, including mid-operation): busy, d_valid, last = 0; k, areg, breg, mreg = 0; d_out = 0.

## Timing
- Start accepted when busy=0, or when last=1 and hold=0 (back-to-back, no bubble). Start in any other cycle is ignored; the running operation continues unchanged.
- Start accepted in cycle T → digit 0 valid in T+1, digit N−1 in T+N (no holds); each hold cycle adds exactly one.
- hold while IDLE has no effect; start with hold=1 while IDLE is accepted.
- last is high for exactly one non-held cycle per operation (held cycles on digit N−1 repeat it).
- Throughput: one operation per N cycles when streaming.

## Structure
- Package nanov_shift_pkg: op encodings (OP_SLL, OP_SRL, OP_SRA), mode enum (SH_SLL, SH_SRL, SH_SRA, SH_ROL, SH_ROR), decode function (op, rotate) → mode.
- Sub-module nanov_shift_bitsel: combinational, given (mode, breg, bit index i, areg) returns result bit; instantiated DIGIT times. Top holds registers, counter and handshake.

## Test plan
- XLEN=32, DIGIT=1: SLL a=0x000000F1, b=4 → 32 bits LSB-first forming 0x00000F10; last in cycle T+32 only.
- DIGIT=4: SRA a=0x80000000, b=31 → 8 digits 0xF; SRL same operands → digit0=0x1, rest 0x0.
- DIGIT=8: ROR a=0x00000001, b=1 → digits 00,00,00,80; ROL a=0x80000001, b=4 → 18,00,00,00; b=0 any mode returns a.
- DIGIT=4, SLL a=0x12345678, b=0: hold high 3 cycles on digit 2 → d_out stays 0x6, last at T+11, digits 8,7,6,5,4,3,2,1.
- Start with new operands in last cycle → next op's digit 0 the following cycle, no idle gap; start at k=3 mid-op ignored, result unchanged.
- rstn low at k=5 → busy, d_valid, last, d_out all 0 immediately; after release, start produces correct full result.
